// File: rtl/sdiv_pkg.sv
// Shared types and constants for the sequential signed divider.
package sdiv_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/sdiv_seq_if.sv
// Request/result bundle of the sequential signed divider.
interface sdiv_seq_if #(parameter int WIDTH = sdiv_pkg::DEF_WIDTH);

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/sdiv_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module sdiv_step
  import sdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] pr_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] pr_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // NOTE: every variable is assigned on every path through always_comb, so no latch is inferred.
  always_comb begin
    shifted = {pr_in, bit_in};
    q_bit   = (shifted >= {1'b0, dvs});
    // The kept remainder is always below |divisor|, so W bits hold it.
    pr_out  = q_bit ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/sdiv_seq.sv
// Sequential signed divider: 2W/W -> W-bit quotient and remainder over W+1 cycles.
module sdiv_seq
  import sdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  sdiv_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pr, dvd_lo, dvs_mag, q_acc;
  logic             sgn_dvd, sgn_dvs, dz, ovf;
  logic             busy_r, done_r, dz_r, ovf_r;
  logic [WIDTH-1:0] quo_r, rem_r;

  // Magnitudes of the raw inputs; the most negative values map onto 2^(n-1) unsigned.
  logic [2*WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic               early_dz, early_ovf;

  assign dvd_abs   = bus.dividend[2*WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_abs   = bus.divisor[WIDTH-1]    ? -bus.divisor  : bus.divisor;
  assign early_dz  = (bus.divisor == '0);
  assign early_ovf = (dvd_abs[2*WIDTH-1:WIDTH] >= dvs_abs);

  logic [WIDTH-1:0] pr_nxt;
  logic             q_bit;

  sdiv_step #(.WIDTH(WIDTH)) u_step (
    .pr_in  (pr),
    .bit_in (dvd_lo[WIDTH-1]),
    .dvs    (dvs_mag),
    .pr_out (pr_nxt),
    .q_bit  (q_bit)
  );

  // Sign fix-up and late overflow on the unsigned quotient magnitude.
  logic             q_neg, late_ovf, any_flag;
  logic [WIDTH-1:0] fix_q, fix_r;

  assign q_neg    = sgn_dvd ^ sgn_dvs;
  assign late_ovf = q_neg ? (q_acc[WIDTH-1] && (|q_acc[WIDTH-2:0])) : q_acc[WIDTH-1];
  assign any_flag = dz | ovf | late_ovf;
  assign fix_q    = q_neg   ? -q_acc : q_acc;
  assign fix_r    = sgn_dvd ? -pr    : pr;

  // NOTE: datapath registers are reset along with the FSM so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pr      <= '0;
      dvd_lo  <= '0;
      dvs_mag <= '0;
      q_acc   <= '0;
      sgn_dvd <= 1'b0;
      sgn_dvs <= 1'b0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
      quo_r   <= '0;
      rem_r   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_r  <= 1'b1;
            pr      <= dvd_abs[2*WIDTH-1:WIDTH];
            dvd_lo  <= dvd_abs[WIDTH-1:0];
            dvs_mag <= dvs_abs;
            sgn_dvd <= bus.dividend[2*WIDTH-1];
            sgn_dvs <= bus.divisor[WIDTH-1];
            q_acc   <= '0;
            cnt     <= '0;
            dz      <= early_dz;
            ovf     <= !early_dz && early_ovf;
            state   <= (early_dz || early_ovf) ? FIX : CALC;
          end
        end
        CALC: begin
          pr     <= pr_nxt;
          dvd_lo <= dvd_lo << 1;
          q_acc  <= {q_acc[WIDTH-2:0], q_bit};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          dz_r   <= dz;
          ovf_r  <= !dz && (ovf || late_ovf);
          quo_r  <= any_flag ? '0 : fix_q;
          rem_r  <= any_flag ? '0 : fix_r;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
  assign bus.overflow    = ovf_r;

endmodule
